// File: rtl/cascade_result_reader.sv
// Per-channel result bank behind computing_cascade: captures result beats and drains them
// round-robin over a valid/ready stream. Results overwritten before they are read are counted.
module cascade_result_reader #(
  parameter  int CHANELS   = 4,
  parameter  int PH_WIDTH  = 32,
  parameter  int AC_WIDTH  = 32,
  parameter  int CNT_WIDTH = 16,
  localparam int AW        = $clog2(CHANELS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_vld,
  input  logic signed [PH_WIDTH-1:0] ph,
  input  logic        [AC_WIDTH-1:0] ac,
  input  logic        [AW-1:0]       address_output,
  output logic                       o_vld,
  input  logic                       o_rdy,
  output logic        [AW-1:0]       o_chan,
  output logic signed [PH_WIDTH-1:0] o_ph,
  output logic        [AC_WIDTH-1:0] o_ac,
  output logic        [CHANELS-1:0]  ovr_flags,
  output logic        [CNT_WIDTH-1:0] ovr_cnt,
  input  logic                       clear_ovr
);

  logic signed [PH_WIDTH-1:0]  bank_ph_q [CHANELS];
  logic        [AC_WIDTH-1:0]  bank_ac_q [CHANELS];
  logic        [CHANELS-1:0]   pending_q,    pending_d;
  logic        [AW-1:0]        last_grant_q, last_grant_d;
  logic                        o_vld_q,      o_vld_d;
  logic        [AW-1:0]        o_chan_q,     o_chan_d;
  logic signed [PH_WIDTH-1:0]  o_ph_q,       o_ph_d;
  logic        [AC_WIDTH-1:0]  o_ac_q,       o_ac_d;
  logic        [CHANELS-1:0]   ovr_flags_q,  ovr_flags_d;
  logic        [CNT_WIDTH-1:0] ovr_cnt_q,    ovr_cnt_d;

  logic          grant_found_s;
  logic [AW-1:0] grant_s;
  logic [AW-1:0] cand_s;
  logic          free_s;
  logic          load_s;
  logic          wr_s;
  logic          overrun_s;

  // Round-robin search: first pending channel strictly after the last grant, wrapping.
  always_comb begin
    grant_found_s = 1'b0;
    grant_s       = {AW{1'b0}};
    cand_s        = {AW{1'b0}};
    for (int i = 1; i <= CHANELS; i++) begin
      cand_s = AW'((int'(last_grant_q) + i) % CHANELS);
      if (!grant_found_s && pending_q[cand_s]) begin
        grant_found_s = 1'b1;
        grant_s       = cand_s;
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Load/write qualifiers; a write to the channel being granted this edge is a collision, not an overrun.
  always_comb begin
    free_s    = !o_vld_q || o_rdy;
    load_s    = free_s && grant_found_s;
    wr_s      = i_vld && (int'(address_output) < CHANELS);
    overrun_s = wr_s && pending_q[address_output] && !(load_s && (grant_s == address_output));
  end

  // Next-state for pending set, output register and overrun bookkeeping.
  always_comb begin
    pending_d    = pending_q;
    last_grant_d = last_grant_q;
    o_vld_d      = o_vld_q;
    o_chan_d     = o_chan_q;
    o_ph_d       = o_ph_q;
    o_ac_d       = o_ac_q;
    ovr_flags_d  = ovr_flags_q;
    ovr_cnt_d    = ovr_cnt_q;

    if (free_s) begin
      if (grant_found_s) begin
        o_vld_d            = 1'b1;
        o_chan_d           = grant_s;
        o_ph_d             = bank_ph_q[grant_s];
        o_ac_d             = bank_ac_q[grant_s];
        pending_d[grant_s] = 1'b0;
        last_grant_d       = grant_s;
      end else begin
        o_vld_d = 1'b0;
      end
    end else begin
      o_vld_d = o_vld_q;
    end

    // Set after the grant clear so a colliding write keeps the channel pending.
    if (wr_s) begin
      pending_d[address_output] = 1'b1;
    end else begin
      pending_d = pending_d;
    end

    if (clear_ovr) begin
      ovr_flags_d = {CHANELS{1'b0}};
      ovr_cnt_d   = {CNT_WIDTH{1'b0}};
    end else begin
      ovr_cnt_d = ovr_cnt_d;
    end

    if (overrun_s) begin
      ovr_flags_d[address_output] = 1'b1;
      if (ovr_cnt_d != {CNT_WIDTH{1'b1}}) begin
        ovr_cnt_d = ovr_cnt_d + CNT_WIDTH'(1);
      end else begin
        ovr_cnt_d = ovr_cnt_d;
      end
    end else begin
      ovr_flags_d = ovr_flags_d;
    end
  end

  // State registers and bank storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q    <= {CHANELS{1'b0}};
      last_grant_q <= AW'(CHANELS - 1);
      o_vld_q      <= 1'b0;
      o_chan_q     <= {AW{1'b0}};
      o_ph_q       <= {PH_WIDTH{1'b0}};
      o_ac_q       <= {AC_WIDTH{1'b0}};
      ovr_flags_q  <= {CHANELS{1'b0}};
      ovr_cnt_q    <= {CNT_WIDTH{1'b0}};
      for (int i = 0; i < CHANELS; i++) begin
        bank_ph_q[i] <= {PH_WIDTH{1'b0}};
        bank_ac_q[i] <= {AC_WIDTH{1'b0}};
      end
    end else begin
      pending_q    <= pending_d;
      last_grant_q <= last_grant_d;
      o_vld_q      <= o_vld_d;
      o_chan_q     <= o_chan_d;
      o_ph_q       <= o_ph_d;
      o_ac_q       <= o_ac_d;
      ovr_flags_q  <= ovr_flags_d;
      ovr_cnt_q    <= ovr_cnt_d;
      if (wr_s) begin
        bank_ph_q[address_output] <= ph;
        bank_ac_q[address_output] <= ac;
      end
    end
  end

  assign o_vld     = o_vld_q;
  assign o_chan    = o_chan_q;
  assign o_ph      = o_ph_q;
  assign o_ac      = o_ac_q;
  assign ovr_flags = ovr_flags_q;
  assign ovr_cnt   = ovr_cnt_q;

endmodule
